// File: rtl/vga_image_window_if.sv
// Memory read bus between the image window and the frame/data memory.
//   master : drives mem_addr/mem_rd, receives data_rgb/data_gray
//   slave  : the memory side
//   mem_addr  [ADDR_W] read address
//   mem_rd    [1]      read strobe
//   data_rgb  [24]     RGB888 read data
//   data_gray [32]     four packed 8-bit gray pixels, byte 0 in the LSBs
interface vga_image_window_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [23:0]       data_rgb;
    logic [31:0]       data_gray;

    modport master (
        output mem_addr,
        output mem_rd,
        input  data_rgb,
        input  data_gray
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output data_rgb,
        output data_gray
    );
endinterface

// File: rtl/vga_image_window.sv
// Pipelined pixel-colour generator: places an IMG_W x IMG_H image at (WIN_X0, WIN_Y0) with
// 2^SCALE_LOG2 replication, issues memory reads and aligns returned data with the beam.
// Rendering mode (solid / RGB888 / 8-bit gray) is latched once per frame at (0,0).
// Optional build macro: VGA_WIN_BORDER_EN draws a one-pixel white border around the window.
// Ports:
//   i_clk, i_reset_n          pixel clock, async active-low reset
//   i_x, i_y, i_video_on      beam position and active-region flag
//   i_mode                    0 solid, 1 RGB888, 2 gray, 3 treated as solid
//   mem_if (master)           read address/strobe out, read data in
//   o_red/o_green/o_blue      registered colour, RD_LAT+1 cycles after x/y
//   o_de_out                  video_on aligned with the colour
//   o_frame_cnt               frames since reset (wraps)
module vga_image_window #(
    parameter int              WIN_X0     = 200,
    parameter int              WIN_Y0     = 120,
    parameter int              IMG_W      = 256,
    parameter int              IMG_H      = 256,
    parameter int unsigned     SCALE_LOG2 = 0,
    parameter int unsigned     RD_LAT     = 1,
    parameter int unsigned     ADDR_W     = 16,
    parameter logic [23:0]     SOLID_RGB  = 24'h6296A1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [9:0]          i_x,
    input  logic [9:0]          i_y,
    input  logic                i_video_on,
    input  logic [1:0]          i_mode,
    vga_image_window_if.master  mem_if,
    output logic [7:0]          o_red,
    output logic [7:0]          o_green,
    output logic [7:0]          o_blue,
    output logic                o_de_out,
    output logic [7:0]          o_frame_cnt
);

    localparam int WW = IMG_W << SCALE_LOG2;
    localparam int WH = IMG_H << SCALE_LOG2;

    localparam logic [1:0] ModeSolid = 2'd0;
    localparam logic [1:0] ModeRgb   = 2'd1;
    localparam logic [1:0] ModeGray  = 2'd2;

    typedef struct packed {
        logic       win;
        logic       von;
        logic       border;
        logic [1:0] mode;
        logic [1:0] sel;
    } pipe_t;

    logic [1:0]        r_mode;
    logic [7:0]        r_frame_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    pipe_t             r_pipe [0:RD_LAT];
    logic [23:0]       r_rgb;
    logic              r_de;

    int                w_xi;
    int                w_yi;
    int                w_u;
    int                w_v;
    int                w_idx;
    logic              w_frame_start;
    logic [1:0]        w_mode_in;
    logic [1:0]        w_mode_eff;
    logic              w_in_win;
    logic              w_border;
    logic              w_rd;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_sel;
    pipe_t             w_stage0;
    pipe_t             w_tail;
    logic [7:0]        w_gray;
    logic [23:0]       w_rgb;

    // Stage 0: window test and address generation
    always_comb begin
        w_xi          = {22'd0, i_x};
        w_yi          = {22'd0, i_y};
        w_frame_start = (i_x == 10'd0) && (i_y == 10'd0);
        w_mode_in     = (i_mode == 2'd3) ? ModeSolid : i_mode;
        // The frame's first pixel already renders with the newly latched mode
        w_mode_eff    = w_frame_start ? w_mode_in : r_mode;
        w_in_win      = i_video_on &&
                        (w_xi >= WIN_X0) && (w_xi < WIN_X0 + WW) &&
                        (w_yi >= WIN_Y0) && (w_yi < WIN_Y0 + WH);
        w_u           = (w_xi - WIN_X0) >>> SCALE_LOG2;
        w_v           = (w_yi - WIN_Y0) >>> SCALE_LOG2;
        w_idx         = w_v * IMG_W + w_u;
        w_sel         = 2'(w_idx);
        w_rd          = w_in_win && ((w_mode_eff == ModeRgb) || (w_mode_eff == ModeGray));
        w_addr        = (w_mode_eff == ModeGray) ? ADDR_W'(w_idx >>> 2) : ADDR_W'(w_idx);
`ifdef VGA_WIN_BORDER_EN
        // Ring one pixel outside the window; the window itself is excluded
        w_border      = i_video_on && !w_in_win &&
                        (w_xi >= WIN_X0 - 1) && (w_xi <= WIN_X0 + WW) &&
                        (w_yi >= WIN_Y0 - 1) && (w_yi <= WIN_Y0 + WH);
`else
        w_border      = 1'b0;
`endif
        w_stage0.win    = w_in_win;
        w_stage0.von    = i_video_on;
        w_stage0.border = w_border;
        w_stage0.mode   = w_mode_eff;
        w_stage0.sel    = w_sel;
    end

    // Frame latch and counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mode      <= ModeSolid;
            r_frame_cnt <= 8'd0;
        end else if (w_frame_start) begin
            r_mode      <= w_mode_in;
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    // Address register holds its last value when no read is issued
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
        end else begin
            r_mem_rd <= w_rd;
            if (w_rd) begin
                r_mem_addr <= w_addr;
            end
        end
    end

    // r_pipe[0] is aligned with mem_addr; r_pipe[RD_LAT] is aligned with returned data
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i <= int'(RD_LAT); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage0;
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Output stage
    always_comb begin
        w_tail = r_pipe[RD_LAT];
        w_gray = mem_if.data_gray[{w_tail.sel, 3'b000} +: 8];
        w_rgb  = 24'h000000;
        if (w_tail.von) begin
            if (w_tail.border) begin
                w_rgb = 24'hFFFFFF;
            end else if (w_tail.win) begin
                case (w_tail.mode)
                    ModeRgb:  w_rgb = mem_if.data_rgb;
                    ModeGray: w_rgb = {w_gray, w_gray, w_gray};
                    default:  w_rgb = SOLID_RGB;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rgb <= 24'h000000;
            r_de  <= 1'b0;
        end else begin
            r_rgb <= w_rgb;
            r_de  <= w_tail.von;
        end
    end

    assign mem_if.mem_addr = r_mem_addr;
    assign mem_if.mem_rd   = r_mem_rd;
    assign o_red           = r_rgb[23:16];
    assign o_green         = r_rgb[15:8];
    assign o_blue          = r_rgb[7:0];
    assign o_de_out        = r_de;
    assign o_frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_vga_image_window.sv
// Self-checking bench for vga_image_window: directed steps plus random pixels compared with an
// arithmetic reference model. A second instance (origin window, 2x replication) checks addressing.
module tb_vga_image_window;

    localparam int          WIN_X0    = 200;
    localparam int          WIN_Y0    = 120;
    localparam int          IMG_W     = 256;
    localparam int          IMG_H     = 256;
    localparam int          RD_LAT    = 1;
    localparam logic [23:0] SOLID_RGB = 24'h6296A1;
`ifdef VGA_WIN_BORDER_EN
    localparam logic [23:0] BORDER_EXP = 24'hFFFFFF;
`else
    localparam logic [23:0] BORDER_EXP = 24'h000000;
`endif

    logic       clk;
    logic       i_reset_n;
    logic [9:0] i_x;
    logic [9:0] i_y;
    logic       i_video_on;
    logic [1:0] i_mode;
    logic [7:0] red, green, blue, frame_cnt;
    logic       de;
    logic [7:0] s_red, s_green, s_blue, s_frame_cnt;
    logic       s_de;

    int checks = 0;
    int errors = 0;

    vga_image_window_if #(.ADDR_W(16)) u_if ();
    vga_image_window_if #(.ADDR_W(16)) s_if ();

    vga_image_window u_dut (
        .i_clk       (clk),
        .i_reset_n   (i_reset_n),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_video_on  (i_video_on),
        .i_mode      (i_mode),
        .mem_if      (u_if),
        .o_red       (red),
        .o_green     (green),
        .o_blue      (blue),
        .o_de_out    (de),
        .o_frame_cnt (frame_cnt)
    );

    vga_image_window #(
        .WIN_X0     (0),
        .WIN_Y0     (0),
        .SCALE_LOG2 (1)
    ) u_scl (
        .i_clk       (clk),
        .i_reset_n   (i_reset_n),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_video_on  (i_video_on),
        .i_mode      (i_mode),
        .mem_if      (s_if),
        .o_red       (s_red),
        .o_green     (s_green),
        .o_blue      (s_blue),
        .o_de_out    (s_de),
        .o_frame_cnt (s_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content: arbitrary address-derived patterns
    function automatic logic [23:0] rgb_of(input logic [15:0] a);
        return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5, a[7:0] + a[15:8]};
    endfunction

    function automatic logic [31:0] gray_of(input logic [15:0] a);
        return 32'hAABBCCDD ^ {a, a};
    endfunction

    // Memory with RD_LAT cycles of read latency
    logic [15:0] a_hist [RD_LAT];
    always @(posedge clk) begin
        a_hist[0] <= u_if.mem_addr;
        for (int i = 1; i < RD_LAT; i++) a_hist[i] <= a_hist[i-1];
    end
    assign u_if.data_rgb  = rgb_of(a_hist[RD_LAT-1]);
    assign u_if.data_gray = gray_of(a_hist[RD_LAT-1]);
    assign s_if.data_rgb  = 24'h0;
    assign s_if.data_gray = 32'h0;

    // Reference model state
    logic [1:0]  mode_m;
    logic [7:0]  fcnt_m;
    logic [15:0] last_m;
    logic [15:0] last_s;
    logic [24:0] expq [$];

    function automatic bit in_win(input int x, input int y, input int x0, input int y0,
                                  input int f);
        return (x >= x0) && (x < x0 + IMG_W * f) && (y >= y0) && (y < y0 + IMG_H * f);
    endfunction

    function automatic int pix_idx(input int x, input int y, input int x0, input int y0,
                                   input int f);
        return ((y - y0) / f) * IMG_W + (x - x0) / f;
    endfunction

    function automatic bit on_border(input int x, input int y);
        return !in_win(x, y, WIN_X0, WIN_Y0, 1) &&
               (x >= WIN_X0 - 1) && (x <= WIN_X0 + IMG_W) &&
               (y >= WIN_Y0 - 1) && (y <= WIN_Y0 + IMG_H);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode_m = 2'd0;
        fcnt_m = 8'd0;
        last_m = 16'd0;
        last_s = 16'd0;
        expq.delete();
        for (int i = 0; i <= RD_LAT; i++) expq.push_back(25'd0);
    endtask

    task automatic step(input int x, input int y, input bit von, input logic [1:0] m);
        logic [24:0] e;
        logic [31:0] word;
        int          idx;
        bit          win;
        bit          rd;
        @(negedge clk);
        i_x        = 10'(x);
        i_y        = 10'(y);
        i_video_on = von;
        i_mode     = m;
        @(posedge clk);
        #1;
        if (x == 0 && y == 0) begin
            mode_m = (m == 2'd3) ? 2'd0 : m;
            fcnt_m = fcnt_m + 8'd1;
        end
        // Main instance: read issue
        win = von && in_win(x, y, WIN_X0, WIN_Y0, 1);
        idx = win ? pix_idx(x, y, WIN_X0, WIN_Y0, 1) : 0;
        rd  = win && (mode_m == 2'd1 || mode_m == 2'd2);
        if (rd) last_m = (mode_m == 2'd2) ? 16'(idx / 4) : 16'(idx);
        chk("mem_rd", {31'd0, u_if.mem_rd}, {31'd0, rd});
        chk("mem_addr", {16'd0, u_if.mem_addr}, {16'd0, last_m});
        chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, fcnt_m});
        // Scaled instance: read issue
        begin
            bit w2;
            int i2;
            bit r2;
            w2 = von && in_win(x, y, 0, 0, 2);
            i2 = w2 ? pix_idx(x, y, 0, 0, 2) : 0;
            r2 = w2 && (mode_m == 2'd1 || mode_m == 2'd2);
            if (r2) last_s = (mode_m == 2'd2) ? 16'(i2 / 4) : 16'(i2);
            chk("s_mem_rd", {31'd0, s_if.mem_rd}, {31'd0, r2});
            chk("s_mem_addr", {16'd0, s_if.mem_addr}, {16'd0, last_s});
        end
        // Main instance: expected colour for this pixel, emerging RD_LAT+1 cycles later
        e = {von, 24'h000000};
        if (von) begin
`ifdef VGA_WIN_BORDER_EN
            if (on_border(x, y)) e[23:0] = 24'hFFFFFF;
`endif
            if (win) begin
                if (mode_m == 2'd1) begin
                    e[23:0] = rgb_of(16'(idx));
                end else if (mode_m == 2'd2) begin
                    word = gray_of(16'(idx / 4));
                    e[23:0] = {3{word[8 * (idx % 4) +: 8]}};
                end else begin
                    e[23:0] = SOLID_RGB;
                end
            end
        end
        expq.push_back(e);
        if (expq.size() > RD_LAT + 1) begin
            e = expq.pop_front();
            chk("colour", {8'd0, red, green, blue}, {8'd0, e[23:0]});
            chk("de_out", {31'd0, de}, {31'd0, e[24]});
        end
    endtask

    // Directed pixel with exact-latency check of its colour
    task automatic lit(input string tag, input int x, input int y, input logic [1:0] m,
                       input logic [23:0] exp);
        step(5, 5, 1'b0, m);
        step(x, y, 1'b1, m);
        repeat (RD_LAT) step(5, 5, 1'b0, m);
        chk({tag, "_early"}, {8'd0, red, green, blue}, 32'h0);
        step(5, 5, 1'b0, m);
        chk(tag, {8'd0, red, green, blue}, {8'd0, exp});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rgb"}, {8'd0, red, green, blue}, 32'h0);
        chk({tag, "_de"}, {31'd0, de}, 32'h0);
        chk({tag, "_rd"}, {31'd0, u_if.mem_rd}, 32'h0);
        chk({tag, "_addr"}, {16'd0, u_if.mem_addr}, 32'h0);
        chk({tag, "_fcnt"}, {24'd0, frame_cnt}, 32'h0);
    endtask

    initial begin
        logic [7:0] fsave;
        int         rx, ry;
        i_reset_n  = 1'b0;
        i_x        = 10'd5;
        i_y        = 10'd5;
        i_video_on = 1'b0;
        i_mode     = 2'd0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #2;
        i_reset_n = 1'b1;
        model_reset();

        // Solid frame and window edges
        step(0, 0, 1'b1, 2'd0);
        lit("solid_tl", 200, 120, 2'd0, SOLID_RGB);
        lit("solid_br", 455, 375, 2'd0, SOLID_RGB);
        lit("left_out", 199, 120, 2'd0, 24'h0);
        lit("right_out", 456, 120, 2'd0, 24'h0);
        lit("bottom_out", 300, 376, 2'd0, 24'h0);
        lit("solid_noviden", 300, 200, 2'd0, SOLID_RGB);

        // RGB frame, then mid-frame request for gray
        step(0, 0, 1'b1, 2'd1);
        step(201, 121, 1'b1, 2'd1);
        chk("addr257", {16'd0, u_if.mem_addr}, 32'd257);
        lit("rgb257", 201, 121, 2'd1, rgb_of(16'd257));
        lit("midframe_rgb", 210, 130, 2'd2, rgb_of(16'd2570));
        step(0, 0, 1'b1, 2'd2);
        step(203, 120, 1'b1, 2'd2);
        chk("gray_addr0", {16'd0, u_if.mem_addr}, 32'd0);
        lit("gray_sel3", 203, 120, 2'd2, 24'hAAAAAA);
        lit("gray_sel0", 200, 120, 2'd2, 24'hDDDDDD);

        // Border ring
        step(199, 200, 1'b1, 2'd1);
        chk("border_l_rd", {31'd0, u_if.mem_rd}, 32'd0);
        lit("border_l", 199, 200, 2'd1, BORDER_EXP);
        lit("border_r", 456, 200, 2'd1, BORDER_EXP);

        // Scaled instance addressing (origin window, 2x)
        step(0, 0, 1'b1, 2'd1);
        step(1, 0, 1'b1, 2'd1);
        chk("scl_x1", {16'd0, s_if.mem_addr}, 32'd0);
        step(2, 0, 1'b1, 2'd1);
        chk("scl_x2", {16'd0, s_if.mem_addr}, 32'd1);
        step(0, 2, 1'b1, 2'd1);
        chk("scl_y2", {16'd0, s_if.mem_addr}, 32'd256);
        step(512, 0, 1'b1, 2'd1);
        chk("scl_x512_rd", {31'd0, s_if.mem_rd}, 32'd0);

        // Random pixels around the window with occasional frame starts
        for (int n = 0; n < 400; n++) begin
            rx = $urandom_range(150, 520);
            ry = $urandom_range(80, 420);
            if ($urandom_range(0, 49) == 0) begin
                rx = 0;
                ry = 0;
            end
            step(rx, ry, ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)));
        end

        // Reset mid-frame
        step(0, 0, 1'b1, 2'd1);
        step(210, 130, 1'b1, 2'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk_zero("midreset");
        i_reset_n = 1'b1;
        model_reset();
        lit("post_rst_solid", 210, 130, 2'd1, SOLID_RGB);
        step(0, 0, 1'b1, 2'd1);
        lit("post_rst_rgb", 210, 130, 2'd1, rgb_of(16'd2570));

        // Frame counter wrap
        fsave = frame_cnt;
        repeat (256) step(0, 0, 1'b0, 2'd0);
        chk("fcnt_wrap", {24'd0, frame_cnt}, {24'd0, fsave});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
